ppcm_arbiter: RTL and testbench
===============================

// Module: ppcm_arbiter
// PURPOSE
//  Shares one read-only parallel-PCM core among NUM_MASTERS requesters (e.g. I-fetch, D-read, DMA).
//  Grants one master per transaction (single word or 16-byte burst) and muxes cs/addr/burst into the core.
//  Routes the core's ack back to the granted master only; dout is broadcast to all masters.
//  Sits between the bus masters and the PCM core, in the core's clock domain.
// PARAMETERS
//  NUM_MASTERS  2   number of requesters, 2..4
//  ADDR_BITS    24  PCM byte-address width; word address is [ADDR_BITS-1:2]
// PORTS
//  clk         in   1                          system clock
//  rst         in   1                          synchronous, active-high reset
//  m_cs        in   NUM_MASTERS                per-master request, held until final ack
//  m_addr      in   NUM_MASTERS*(ADDR_BITS-2)  per-master word address; master i occupies slice i
//  m_burst     in   NUM_MASTERS                per-master burst flag
//  m_dout      out  32                         read data, broadcast (= core_dout)
//  m_busy      out  NUM_MASTERS                per-master stall
//  m_ack       out  NUM_MASTERS                per-master word acknowledge
//  grant       out  NUM_MASTERS                one-hot current owner, registered
//  core_cs     out  1                          to core cs
//  core_addr   out  ADDR_BITS-2                to core addr
//  core_burst  out  1                          to core burst
//  core_dout   in   32                         from core dout
//  core_busy   in   1                          from core busy (high during init and ops)
//  core_ack    in   1                          from core ack, one pulse per 32-bit word
// BEHAVIOUR
//  Reset: state=S_INIT, grant=0, rr pointer=0; m_ack=0; m_busy=all 1; core_cs=0.
//  S_INIT:   wait for the first cycle with core_busy==0, then go to S_IDLE. Requests are not issued.
//            Required because core_busy is high for the whole core init.
//  S_IDLE:   if any m_cs, register the winner into grant and go to S_ISSUE. No request: grant stays 0.
//            Arbitration takes exactly 1 cycle.
//  S_ISSUE:  core_cs=m_cs[g], core_addr/core_burst from master g. core_busy==1 -> S_ACTIVE.
//            m_cs[g] dropped before the core starts: abort to S_IDLE, no ack, pointer not advanced.
//  S_ACTIVE: core_cs=m_cs[g] & core_busy, so the burst continues while the master holds cs.
//            core_busy==0 -> core_cs low in that same cycle, clear grant, advance pointer to g+1 (mod N), go to S_IDLE.
//            The core therefore never sees cs when it re-enters IDLE without arbitration.
//  Mux: core_cs/core_addr/core_burst are combinational from the registered grant; zero when grant==0.
//  m_ack[i]  = core_ack & grant[i]. Non-granted masters never see ack.
//  m_busy[i] = (state==S_INIT) | (grant[i] & state!=S_IDLE) | (m_cs[i] & ~grant[i]).
//  Round robin: search starts at the pointer; the lowest index at or after the pointer wins.
//  Master requesting in the same cycle the owner releases: waits for the next S_IDLE cycle (1-cycle bubble).
//  rst mid-transaction: grant=0 immediately, return to S_INIT. The core is reset by the same rst.
//  The arbiter does not count burst words; the core stops a burst at a 16-byte boundary.
// CONFIGURATION
//  PPCM_ARB_FIXED_PRIO_EN defined: fixed priority, master 0 highest. The rr pointer is removed and never advances.
//  Not defined (default): round robin as above.
// STRUCTURE
//  State encodings S_INIT..S_ACTIVE as localparams in define.vh; use GET_WIDTH from function.vh.
//  One sub-module: ppcm_rr_picker. Combinational, inputs (req, ptr), output one-hot winner.
//  The fixed-priority build ties ptr=0.
// TESTING
//  Reset with core_busy held 1 for 50 cycles, m_cs=01 -> no core_cs until busy falls; then grant=01.
//  m_cs=11 simultaneous, single reads (burst=0):
//    order master0, master1, master0, ... ; each m_ack a single pulse to its owner only.
//  Master0 burst at word addr 0x100 -> 4 acks to master0; master1 request held the whole time;
//    master1 granted only after core_busy falls.
//  Master1 drops m_cs in S_ISSUE before core_busy rises -> back to S_IDLE, zero acks, pointer unchanged.
//  rst asserted during S_ACTIVE -> grant=0, m_ack=0, m_busy=all 1 the next cycle; back to S_INIT.
//  PPCM_ARB_FIXED_PRIO_EN with m_cs=11 held -> master0 granted on every transaction, master1 starved.

Source files
------------

// File: rtl/ppcm_arbiter_pkg.sv
// Shared types and helpers for the parallel-PCM arbiter slice.
package ppcm_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ISSUE  = 2'd2,
    S_ACTIVE = 2'd3
  } arb_state_e;

  localparam int MAX_MASTERS = 4;

  // Bits needed to hold an index 0..n-1 (never less than one bit)
  function automatic int get_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ppcm_rr_picker.sv
// Combinational rotating-priority picker: the lowest requesting index at or
// after i_ptr (wrapping) wins. o_win is one-hot, or zero when nothing requests.
module ppcm_rr_picker
  import ppcm_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int PW          = get_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [PW-1:0]          i_ptr,
  output logic [NUM_MASTERS-1:0] o_win
);

  logic [PW-1:0] w_idx;

  // Scan from farthest to nearest so the nearest requester is written last
  always_comb begin
    o_win = '0;
    w_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_idx = PW'((int'(i_ptr) + k) % NUM_MASTERS);
      if (i_req[w_idx]) begin
        o_win        = '0;
        o_win[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppcm_arbiter.sv
// ppcm_arbiter: shares one read-only parallel-PCM core among NUM_MASTERS
// requesters. One master owns the core per transaction (word or 16-byte
// burst); ack is routed to the owner only, read data is broadcast.
// Build option: define PPCM_ARB_FIXED_PRIO_EN for fixed priority (master 0
// highest, no rotating pointer). Default build is round robin.
module ppcm_arbiter
  import ppcm_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_BITS   = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               m_cs,
  input  logic [NUM_MASTERS*(ADDR_BITS-2)-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]               m_burst,
  output logic [31:0]                          m_dout,
  output logic [NUM_MASTERS-1:0]               m_busy,
  output logic [NUM_MASTERS-1:0]               m_ack,
  output logic [NUM_MASTERS-1:0]               grant,
  output logic                                 core_cs,
  output logic [ADDR_BITS-3:0]                 core_addr,
  output logic                                 core_burst,
  input  logic [31:0]                          core_dout,
  input  logic                                 core_busy,
  input  logic                                 core_ack
);

  localparam int AW = ADDR_BITS - 2;
  localparam int PW = get_width(NUM_MASTERS);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [NUM_MASTERS-1:0] w_win;
  logic [PW-1:0]          w_ptr;
  logic [PW-1:0]          w_gidx;
  logic                   w_gvld;
  logic                   w_gcs;

  ppcm_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .PW          (PW)
  ) u_picker (
    .i_req (m_cs),
    .i_ptr (w_ptr),
    .o_win (w_win)
  );

  // Binary index of the registered owner, used by the request mux
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_gidx = PW'(i);
    end
  end

  assign w_gvld     = |r_grant;
  assign w_gcs      = |(m_cs & r_grant);
  assign core_addr  = w_gvld ? m_addr[int'(w_gidx)*AW +: AW] : '0;
  assign core_burst = |(m_burst & r_grant);

  assign m_dout = core_dout;
  assign m_ack  = {NUM_MASTERS{core_ack}} & r_grant;
  assign grant  = r_grant;
  // Owner stalls for its whole transaction; others stall while they wait
  assign m_busy = {NUM_MASTERS{r_state == S_INIT}}
                | (r_grant & {NUM_MASTERS{r_state != S_IDLE}})
                | (m_cs & ~r_grant);

`ifdef PPCM_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_ptr;
  logic          w_advance;

  // A completed transaction hands first pick to the next master up
  assign w_advance = (r_state == S_ACTIVE) && !core_busy;

  // Round-robin pointer; aborted transactions leave it untouched
  always_ff @(posedge clk) begin
    if (rst)            r_ptr <= '0;
    else if (w_advance) r_ptr <= PW'((int'(w_gidx) + 1) % NUM_MASTERS);
  end

  assign w_ptr = r_ptr;
`endif

  // Next state, next grant and the core chip-select for the current state
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    core_cs     = 1'b0;
    case (r_state)
      S_INIT: begin
        // core_busy stays high for the whole core init
        if (!core_busy) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (|m_cs) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_cs = w_gcs;
        if (core_busy) begin
          w_state_nxt = S_ACTIVE;
        end else if (!w_gcs) begin
          // owner withdrew before the core started: no ack, no pointer move
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        // cs drops in the same cycle busy falls so the core never restarts
        core_cs = w_gcs & core_busy;
        if (!core_busy) begin
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // State and grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

endmodule

// File: tb/tb_ppcm_arbiter.sv
// Self-checking bench for ppcm_arbiter: behavioural PCM core, transaction-level
// arbiter model compared every cycle, plus directed scenarios with literal
// expectations and a randomized phase.
module tb_ppcm_arbiter;

  localparam int N  = 2;
  localparam int AB = 24;
  localparam int AW = AB - 2;
`ifdef PPCM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cs = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N-1:0]    m_burst = '0;
  logic [31:0]     m_dout;
  logic [N-1:0]    m_busy, m_ack, grant;
  logic            core_cs, core_burst;
  logic [AW-1:0]   core_addr;

  // core model state
  logic [31:0] c_dout = '0;
  logic        c_busy = 1'b1;
  logic        c_ack  = 1'b0;
  int          c_init = 50, c_words = 0, c_lat = 0, init_len = 50;

  ppcm_arbiter #(.NUM_MASTERS(N), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .m_cs(m_cs), .m_addr(m_addr), .m_burst(m_burst),
    .m_dout(m_dout), .m_busy(m_busy), .m_ack(m_ack), .grant(grant),
    .core_cs(core_cs), .core_addr(core_addr), .core_burst(core_burst),
    .core_dout(c_dout), .core_busy(c_busy), .core_ack(c_ack)
  );

  always #5 clk = ~clk;

  // Behavioural PCM core: busy through init, then one ack per word, burst
  // stops at the 16-byte boundary, busy falls together with the last ack.
  always @(posedge clk) begin
    if (rst) begin
      c_busy <= 1'b1; c_init <= init_len; c_ack <= 1'b0; c_words <= 0; c_lat <= 0;
    end else if (c_init > 0) begin
      c_ack <= 1'b0;
      c_init <= c_init - 1;
      if (c_init == 1) c_busy <= 1'b0;
    end else if (!c_busy) begin
      c_ack <= 1'b0;
      if (core_cs) begin
        c_busy  <= 1'b1;
        c_words <= core_burst ? 4 - int'(core_addr[1:0]) : 1;
        c_lat   <= int'($urandom_range(1, 3));
      end
    end else if (!core_cs) begin
      c_busy <= 1'b0; c_ack <= 1'b0;
    end else if (c_lat > 1) begin
      c_lat <= c_lat - 1; c_ack <= 1'b0;
    end else begin
      c_ack  <= 1'b1;
      c_dout <= $urandom;
      if (c_words == 1) c_busy <= 1'b0;
      else begin
        c_words <= c_words - 1;
        c_lat   <= int'($urandom_range(1, 3));
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  int mo_owner = -1;
  bit mo_started = 1'b0;
  bit mo_init = 1'b0;
  int mo_ptr = 0;

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mo_owner <= -1; mo_started <= 1'b0; mo_init <= 1'b0; mo_ptr <= 0;
    end else if (!mo_init) begin
      if (!c_busy) mo_init <= 1'b1;
    end else if (mo_owner < 0) begin
      if (|m_cs) mo_owner <= pick(m_cs, mo_ptr);
    end else if (!mo_started) begin
      if (c_busy) mo_started <= 1'b1;
      else if (!m_cs[mo_owner]) mo_owner <= -1;
    end else if (!c_busy) begin
      mo_owner   <= -1;
      mo_started <= 1'b0;
      if (!FIXED) mo_ptr <= (mo_owner + 1) % N;
    end
  end

  logic [N-1:0]  e_grant, e_ack, e_busy;
  logic          e_cs, e_burst;
  logic [AW-1:0] e_addr;

  always_comb begin
    e_grant = '0; e_ack = '0; e_busy = '0; e_cs = 1'b0; e_burst = 1'b0; e_addr = '0;
    if (mo_owner >= 0) begin
      e_grant[mo_owner] = 1'b1;
      e_ack[mo_owner]   = c_ack;
      e_addr            = m_addr[mo_owner*AW +: AW];
      e_burst           = m_burst[mo_owner];
      e_cs              = mo_started ? (m_cs[mo_owner] & c_busy) : m_cs[mo_owner];
    end
    for (int i = 0; i < N; i++)
      e_busy[i] = !mo_init || (mo_owner == i) || (m_cs[i] && (mo_owner != i));
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", grant, e_grant);
      chk("m_ack", m_ack, e_ack);
      chk("m_busy", m_busy, e_busy);
      chk("core_cs", core_cs, e_cs);
      chk("core_addr", core_addr, e_addr);
      chk("core_burst", core_burst, e_burst);
      chk("m_dout", m_dout, c_dout);
    end
  end

  // ---------------- master drivers ----------------
  logic [N-1:0]  act = '0;
  int            left[N];
  int            reps[N];
  int            ack_cnt[N];
  logic [AW-1:0] q_addr[N];
  logic          q_burst[N];
  bit            rnd_mode = 1'b0;
  logic [N-1:0]  s_grant, s_ack, s_busy, prev_grant = '0;
  logic          s_cs, s_cbusy;
  int            dut_order[$];

  // One clock: snapshot outputs mid-cycle, then let each master act.
  task automatic cyc();
    @(negedge clk);
    s_grant = grant; s_ack = m_ack; s_busy = m_busy; s_cs = core_cs; s_cbusy = c_busy;
    if (s_grant != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (s_grant[i]) dut_order.push_back(i);
    prev_grant = s_grant;
    #2;
    if (rst) begin
      act = '0; m_cs = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if (s_ack[i]) begin
            ack_cnt[i]++;
            left[i]--;
            if (left[i] == 0) begin act[i] = 1'b0; m_cs[i] = 1'b0; end
          end
        end else if (rnd_mode ? ($urandom_range(0, 3) == 0) : (reps[i] > 0)) begin
          if (rnd_mode) begin
            q_addr[i]  = AW'($urandom);
            q_burst[i] = 1'($urandom_range(0, 1));
          end else reps[i]--;
          act[i]  = 1'b1;
          left[i] = q_burst[i] ? 4 - int'(q_addr[i][1:0]) : 1;
          m_cs[i] = 1'b1;
          m_addr[i*AW +: AW] = q_addr[i];
          m_burst[i] = q_burst[i];
        end
      end
    end
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      cyc();
      if (s_grant == g) break;
    end
    chk(name, s_grant, g);
  endtask

  task automatic wait_quiet(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      cyc();
      if (act == '0 && s_grant == '0) break;
    end
    chk(name, {act, s_grant}, '0);
  endtask

  task automatic wait_orders(input int cnt, input int budget);
    for (int k = 0; k < budget && dut_order.size() < cnt; k++) cyc();
  endtask

  task automatic do_reset(input int ilen);
    init_len = ilen;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < N; i++) reps[i] = 0;
    wait_quiet(ilen + 10, "reset_settle");
  endtask

  int viol, b0, b1;
  int exp_ord[4];

  initial begin
    for (int i = 0; i < N; i++) begin
      left[i] = 0; reps[i] = 0; ack_cnt[i] = 0; q_addr[i] = '0; q_burst[i] = 1'b0;
    end
    // reset state
    repeat (3) cyc();
    chk("rst_grant", s_grant, '0);
    chk("rst_ack", s_ack, '0);
    chk("rst_busy", s_busy, {N{1'b1}});
    chk("rst_core_cs", s_cs, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;

    // core init holds master 0 off until busy falls
    q_addr[0] = 22'h40; q_burst[0] = 1'b0; reps[0] = 1;
    viol = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (s_cs || s_grant != '0 || !s_busy[0]) viol++;
    end
    chk("init_hold", viol, 0);
    wait_grant(2'b01, 40, "first_grant");
    wait_quiet(60, "quiet_first");
    chk("first_acks", ack_cnt[0], 1);

    // both masters, single reads, from a fresh pointer
    do_reset(8);
    dut_order.delete();
    b0 = ack_cnt[0]; b1 = ack_cnt[1];
    q_addr[0] = 22'h10; q_burst[0] = 1'b0; reps[0] = 4;
    q_addr[1] = 22'h23; q_burst[1] = 1'b0; reps[1] = 3;
    wait_orders(4, 300);
    chk("order_len", dut_order.size() >= 4, 1'b1);
    exp_ord = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) chk($sformatf("order_%0d", k), dut_order[k], exp_ord[k]);
    wait_quiet(300, "quiet_order");
    chk("order_acks0", ack_cnt[0] - b0, 4);
    chk("order_acks1", ack_cnt[1] - b1, 3);

    // master 0 burst at 0x100 while master 1 waits
    b0 = ack_cnt[0]; b1 = ack_cnt[1];
    dut_order.delete();
    q_addr[0] = 22'h100; q_burst[0] = 1'b1; reps[0] = 1;
    cyc();
    q_addr[1] = 22'h21; q_burst[1] = 1'b0; reps[1] = 1;
    wait_grant(2'b10, 200, "burst_then_m1");
    chk("burst_acks_m0", ack_cnt[0] - b0, 4);
    chk("burst_acks_m1", ack_cnt[1] - b1, 0);
    chk("burst_first_owner", dut_order[0], 0);
    wait_quiet(100, "quiet_burst");

    // master 0 single read moves the pointer, then master 1 aborts in issue
    q_addr[0] = 22'h5; q_burst[0] = 1'b0; reps[0] = 1;
    wait_quiet(60, "quiet_pre_abort");
    q_addr[1] = 22'h77; q_burst[1] = 1'b0; reps[1] = 1;
    wait_grant(2'b10, 20, "abort_grant");
    act[1] = 1'b0; m_cs[1] = 1'b0;
    b1 = ack_cnt[1];
    repeat (20) cyc();
    chk("abort_grant_clear", s_grant, '0);
    chk("abort_no_ack", ack_cnt[1] - b1, 0);
    dut_order.delete();
    q_addr[0] = 22'h8; q_addr[1] = 22'h9; reps[0] = 1; reps[1] = 1;
    wait_orders(1, 40);
    chk("abort_ptr_kept", dut_order[0], FIXED ? 0 : 1);
    wait_quiet(100, "quiet_abort");

    // reset while the core is mid-burst
    q_addr[0] = 22'h200; q_burst[0] = 1'b1; reps[0] = 1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (s_grant == 2'b01 && s_cbusy) break;
    end
    chk("pre_rst_owner", s_grant, 2'b01);
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_grant", s_grant, '0);
    chk("midrst_ack", s_ack, '0);
    chk("midrst_busy", s_busy, {N{1'b1}});
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_busy", s_busy, {N{1'b1}});
    chk("post_rst_cs", s_cs, 1'b0);
    wait_quiet(40, "quiet_rst");

    // randomized traffic
    rnd_mode = 1'b1;
    repeat (1500) cyc();
    rnd_mode = 1'b0;
    wait_quiet(400, "quiet_random");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
